// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of a combinational ALU, with a single registered result slot.
// The head command drives the ALU directly; its result is captured when the result slot is free or being drained.
module alu_cmd_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_f,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic [2:0]                 alu_f,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  input  logic [WIDTH-1:0]           alu_y,
  input  logic                       alu_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_y,
  output logic                       out_zero,
  output logic [2:0]                 out_f,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                done_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [2:0]       mem_f_q [DEPTH];
  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic             out_zero_q, out_zero_d;
  logic [2:0]       out_f_q, out_f_d;
  logic             out_illegal_q, out_illegal_d;
  logic [15:0]      done_count_q, done_count_d;

  logic head_valid, push, pop, deliver;

  always_comb begin
    head_valid = (count_q != '0);
    in_ready   = (count_q < FULL);
    push       = in_valid && in_ready;
    // A pop and a capture are the same event: the head's ALU result lands in the slot.
    pop        = head_valid && (!out_valid_q || out_ready);
    deliver    = out_valid_q && out_ready;

    alu_f = 3'b000;
    alu_a = '0;
    alu_b = '0;
    if (head_valid) begin
      alu_f = mem_f_q[rptr_q];
      alu_a = mem_a_q[rptr_q];
      alu_b = mem_b_q[rptr_q];
    end

    wptr_d        = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d        = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    done_count_d  = deliver ? done_count_q + 16'd1 : done_count_q;

    out_valid_d   = out_valid_q;
    out_y_d       = out_y_q;
    out_zero_d    = out_zero_q;
    out_f_d       = out_f_q;
    out_illegal_d = out_illegal_q;
    if (pop) begin
      out_valid_d   = 1'b1;
      out_y_d       = alu_y;
      out_zero_d    = alu_zero;
      out_f_d       = alu_f;
      out_illegal_d = (alu_f == 3'b011);
    end else if (deliver) begin
      out_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      out_y_q       <= '0;
      out_zero_q    <= 1'b0;
      out_f_q       <= 3'b000;
      out_illegal_q <= 1'b0;
      done_count_q  <= 16'd0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      out_y_q       <= out_y_d;
      out_zero_q    <= out_zero_d;
      out_f_q       <= out_f_d;
      out_illegal_q <= out_illegal_d;
      done_count_q  <= done_count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_f_q[wptr_q] <= in_f;
      mem_a_q[wptr_q] <= in_a;
      mem_b_q[wptr_q] <= in_b;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_y       = out_y_q;
  assign out_zero    = out_zero_q;
  assign out_f       = out_f_q;
  assign out_illegal = out_illegal_q;
  assign count       = count_q;
  assign done_count  = done_count_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Bench for alu_cmd_queue: behavioural 32-bit ALU on the alu_* ports, directed steps,
// and a scoreboard that predicts each result at acceptance and checks it at delivery.
module tb_alu_cmd_queue;
  localparam int W = 32;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0, in_ready;
  logic [2:0]    in_f = 3'b000;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic [2:0]    alu_f;
  logic [W-1:0]  alu_a, alu_b, alu_y;
  logic          alu_zero;
  logic          out_valid, out_ready = 1'b0;
  logic [W-1:0]  out_y;
  logic          out_zero, out_illegal;
  logic [2:0]    out_f;
  logic [$clog2(D):0] count;
  logic [15:0]   done_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_cmd_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_f(in_f), .in_a(in_a), .in_b(in_b),
    .alu_f(alu_f), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
    .out_f(out_f), .out_illegal(out_illegal), .count(count), .done_count(done_count)
  );

  // f[2] inverts b (with carry-in), f[1:0] selects and/or/add/slt
  function automatic logic [W-1:0] alu_fn(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] bb, s;
    bb = f[2] ? ~b : b;
    s  = a + bb + W'(f[2]);
    case (f[1:0])
      2'b00:   return a & bb;
      2'b01:   return a | bb;
      2'b10:   return s;
      default: return {{(W-1){1'b0}}, s[W-1]};
    endcase
  endfunction

  assign alu_y    = alu_fn(alu_f, alu_a, alu_b);
  assign alu_zero = (alu_y == '0);

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] y;
    logic         z;
    logic [2:0]   f;
    logic         ill;
  } exp_t;

  exp_t sb[$];
  logic [15:0] mdone = 16'd0;
  logic        hold_pending = 1'b0;
  exp_t        held;

  // Scoreboard monitor: samples pre-edge values at each rising edge.
  always @(posedge clk) begin
    exp_t e, cur;
    cur = '{y: out_y, z: out_zero, f: out_f, ill: out_illegal};
    if (reset) begin
      sb.delete();
      mdone = 16'd0;
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) chk("hold_stable", W'(cur), W'(held));
      chk("in_ready_rule", W'(in_ready), W'(count < D));
      chk("count_bound", W'(count <= D), W'(1));
      chk("done_count_model", W'(done_count), W'(mdone));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("stale_result", W'(1), W'(0));
        end else begin
          e = sb.pop_front();
          chk("sb_y", out_y, e.y);
          chk("sb_zero", W'(out_zero), W'(e.z));
          chk("sb_f", W'(out_f), W'(e.f));
          chk("sb_illegal", W'(out_illegal), W'(e.ill));
        end
        mdone = mdone + 16'd1;
      end
      if (in_valid && in_ready) begin
        e.y   = alu_fn(in_f, in_a, in_b);
        e.z   = (e.y == '0);
        e.f   = in_f;
        e.ill = (in_f == 3'b011);
        sb.push_back(e);
      end
      hold_pending = out_valid && !out_ready;
      held = cur;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_one(input string tag, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ey, input logic ez, input logic eill);
    out_ready = 1'b1;
    in_valid = 1'b1; in_f = f; in_a = a; in_b = b;
    step();
    in_valid = 1'b0;
    chk({tag, "_count1"}, W'(count), W'(1));
    chk({tag, "_alu_a"}, alu_a, a);
    chk({tag, "_alu_f"}, W'(alu_f), W'(f));
    step();
    chk({tag, "_valid"}, W'(out_valid), W'(1));
    chk({tag, "_y"}, out_y, ey);
    chk({tag, "_zero"}, W'(out_zero), W'(ez));
    chk({tag, "_f"}, W'(out_f), W'(f));
    chk({tag, "_illegal"}, W'(out_illegal), W'(eill));
    step();
    chk({tag, "_drained"}, W'(out_valid), W'(0));
  endtask

  initial begin
    logic [15:0] dc0;
    int accepted;
    int cyc;

    repeat (2) step();
    reset = 1'b0;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_count", W'(count), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_alu_f", W'(alu_f), W'(0));
    chk("rst_alu_a", alu_a, '0);
    chk("rst_alu_b", alu_b, '0);
    chk("rst_done", W'(done_count), W'(0));
    chk("rst_out_y", out_y, '0);

    do_one("add", 3'b010, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0);
    chk("add_done_count", W'(done_count), W'(1));
    do_one("sub", 3'b110, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0);
    do_one("slt", 3'b111, 32'd2, 32'd9, 32'd1, 1'b0, 1'b0);
    do_one("illegal", 3'b011, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1);
    do_one("legal_after", 3'b001, 32'h0F0, 32'h00F, 32'h0FF, 1'b0, 1'b0);

    // back-pressure: fill the queue behind a stalled result
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_f = 3'b010; in_a = W'(10 + i); in_b = W'(i);
      step();
    end
    in_valid = 1'b0;
    chk("bp_count", W'(count), W'(D));
    chk("bp_in_ready", W'(in_ready), W'(0));
    chk("bp_valid", W'(out_valid), W'(1));
    step();
    chk("bp_hold_y", out_y, 32'd10);
    dc0 = done_count;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_stream_valid", W'(out_valid), W'(1));
      chk("bp_stream_y", out_y, W'(10 + 2 * i));
      step();
    end
    chk("bp_end_valid", W'(out_valid), W'(0));
    chk("bp_end_count", W'(count), W'(0));
    chk("bp_done_plus5", W'(done_count), W'(dc0 + 16'd5));

    // reset discards queued commands and the pending result
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_f = 3'b010; in_a = W'(100 + i); in_b = W'(1);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", W'(count), W'(2));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_valid", W'(out_valid), W'(0));
    chk("mid_rst_count", W'(count), W'(0));
    chk("mid_rst_in_ready", W'(in_ready), W'(1));
    chk("mid_rst_done", W'(done_count), W'(0));
    chk("mid_rst_alu_a", alu_a, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_stale_valid", W'(out_valid), W'(0));
    end

    // random traffic against the scoreboard
    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_f = 3'($urandom_range(0, 7));
      in_a = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 3)) : $urandom;
      in_b = $urandom_range(0, 3) == 0 ? in_a : $urandom;
      if (in_valid && in_ready) accepted++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rand_accepted", W'(accepted), W'(1000));
    cyc = 0;
    while ((out_valid || count != 0) && cyc < 50) begin
      step();
      cyc++;
    end
    chk("rand_drained", W'(out_valid || count != 0), W'(0));
    chk("rand_sb_empty", W'(sb.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the command-queue depth (power of two, >= 2).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-004 Ports SHALL be: in_valid  in  1  command offered.
REQ-005 in_ready  out  1  queue can accept a command.
REQ-006 in_f  in  3  ALU operation code.
REQ-007 in_a, in_b  in  WIDTH  operands.
REQ-008 alu_f  out  3  operation code to the ALU.
REQ-009 alu_a, alu_b  out  WIDTH  operands to the ALU.
REQ-010 alu_y  in  WIDTH  ALU result.
REQ-011 alu_zero  in  1  ALU zero flag.
REQ-012 out_valid  out  1  result register holds an unconsumed result.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 out_y  out  WIDTH  registered result.
REQ-015 out_zero  out  1  registered zero flag.
REQ-016 out_f  out  3  operation code of the registered result.
REQ-017 out_illegal  out  1  registered result came from f=3'b011.
REQ-018 count  out  $clog2(DEPTH)+1  queue occupancy.
REQ-019 done_count  out  16  number of results delivered.

Function
REQ-020 The block SHALL hold a FIFO of DEPTH entries {f, a, b}, preserving acceptance order.
REQ-021 in_ready SHALL equal (count < DEPTH), with no combinational dependence on out_ready.
REQ-022 A command SHALL be written at the clk edge where in_valid && in_ready.
REQ-023 alu_f/alu_a/alu_b SHALL combinationally drive the head entry when count > 0, else all zeros.
REQ-024 The head SHALL be popped and alu_y, alu_zero, head f, (head f == 3'b011) captured into out_y/out_zero/out_f/out_illegal at an edge where count > 0 && (!out_valid || out_ready).
REQ-025 out_valid SHALL be set at a capture edge; cleared at an edge with out_valid && out_ready and no capture; otherwise held.
REQ-026 Output registers SHALL hold stable while out_valid && !out_ready.
REQ-027 Minimum latency: command accepted at edge k (queue empty, result register free) SHALL be captured at edge k+1, so out_valid is high after edge k+1.
REQ-028 Sustained throughput SHALL be one result per cycle when in_valid and out_ready stay high.
REQ-029 Push and pop at the same edge SHALL leave count unchanged; when full, in_ready SHALL be 0 even if a pop occurs that edge.
REQ-030 Read/write pointers SHALL wrap modulo DEPTH.
REQ-031 done_count SHALL increment by 1 at each edge with out_valid && out_ready, wrapping 16'hFFFF -> 16'h0000.
REQ-032 Commands with f=3'b011 SHALL be accepted and passed through normally; only out_illegal marks them.

Reset
REQ-033 When reset is high at a clk edge, count, pointers, out_valid, out_y, out_zero, out_f, out_illegal and done_count SHALL become 0.
REQ-034 Reset SHALL take priority over push/pop/capture that edge; queued commands and any pending result SHALL be discarded.
REQ-035 After reset, in_ready SHALL be 1 and alu_f/alu_a/alu_b SHALL be 0.

Verification (bench connects the 32-bit alu instance to the alu_* ports)
REQ-036 Push f=010, a=5, b=3, out_ready=1 -> one edge later out_valid=1, out_y=8, out_zero=0, out_f=010, done_count=1 after the following edge.
REQ-037 Push f=110, a=7, b=7 -> out_y=0, out_zero=1; push f=111, a=2, b=9 -> out_y=1, out_zero=0.
REQ-038 out_ready=0, push 5 commands back-to-back -> first captured, next 4 queued, count=4, in_ready=0; then out_ready=1 -> 5 results in order, one per cycle, done_count=5.
REQ-039 Push f=011 -> out_illegal=1 on that result, 0 on the next legal one.
REQ-040 Queue 3 commands with out_ready=0, assert reset one cycle -> out_valid=0, count=0, in_ready=1, done_count=0; no stale result appears afterwards.
REQ-041 Random in_valid/out_ready for 1000 commands vs. reference model -> zero mismatches, order preserved, count never exceeds DEPTH.
